// File: rtl/blink_pattern_decoder.sv
// Receive-side decoder for a slot-serial blink signal: recovers slot phase from
// input transitions, captures one bit per slot and declares lock on repeated frames.
module blink_pattern_decoder #(
    parameter int MESSAGE_WIDTH = 32,
    parameter int INDEX_WIDTH   = 5,
    parameter int SLOT_WIDTH    = 21
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     LED_IN,
    output logic [MESSAGE_WIDTH-1:0] pattern,
    output logic                     pattern_valid,
    output logic                     locked,
    output logic [INDEX_WIDTH-1:0]   slot_index,
    output logic                     frame_done,
    output logic                     mismatch
);

    typedef enum logic [1:0] {
        HUNT,
        CAPTURE,
        VERIFY
    } state_t;

    localparam logic [SLOT_WIDTH-1:0]  HALF_SLOT = {1'b1, {(SLOT_WIDTH-1){1'b0}}};
    localparam logic [INDEX_WIDTH-1:0] LAST_SLOT = INDEX_WIDTH'(MESSAGE_WIDTH - 1);

    state_t                   state_q;
    logic                     meta_q;
    logic                     s_q;
    logic                     s_prev_q;
    logic [SLOT_WIDTH-1:0]    phase_q;
    logic [MESSAGE_WIDTH-1:0] capture_q;
    logic [MESSAGE_WIDTH-1:0] capture_d;
    logic [MESSAGE_WIDTH-1:0] pattern_q;
    logic [INDEX_WIDTH-1:0]   slot_q;
    logic                     valid_q;
    logic                     locked_q;
    logic                     done_q;
    logic                     mismatch_q;

    logic edge_w;
    logic strobe_w;
    logic wrap_w;
    logic last_slot_w;

    always_comb begin
        edge_w      = s_q ^ s_prev_q;
        strobe_w    = (phase_q == HALF_SLOT) && !edge_w;
        wrap_w      = (phase_q == '1) && !edge_w;
        last_slot_w = (slot_q == LAST_SLOT);
        // Frame word including the bit being sampled this cycle.
        capture_d         = capture_q;
        capture_d[slot_q] = s_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= HUNT;
            meta_q     <= 1'b0;
            s_q        <= 1'b0;
            s_prev_q   <= 1'b0;
            phase_q    <= '0;
            capture_q  <= '0;
            pattern_q  <= '0;
            slot_q     <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            meta_q     <= LED_IN;
            s_q        <= meta_q;
            s_prev_q   <= s_q;
            phase_q    <= edge_w ? '0 : phase_q + SLOT_WIDTH'(1);
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;

            case (state_q)
                HUNT: begin
                    // slot_q doubles as the idle-slot counter until the first frame starts.
                    if (edge_w) begin
                        state_q <= CAPTURE;
                        slot_q  <= '0;
                    end else if (wrap_w) begin
                        if (last_slot_w) begin
                            state_q <= CAPTURE;
                            slot_q  <= '0;
                        end else begin
                            slot_q <= slot_q + INDEX_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    if (strobe_w) begin
                        capture_q <= capture_d;
                        if (last_slot_w) begin
                            slot_q <= '0;
                            done_q <= 1'b1;
                            if (state_q == CAPTURE) begin
                                pattern_q <= capture_d;
                                valid_q   <= 1'b1;
                                state_q   <= VERIFY;
                            end else if (capture_d == pattern_q) begin
                                locked_q <= 1'b1;
                            end else begin
                                locked_q   <= 1'b0;
                                mismatch_q <= 1'b1;
                                pattern_q  <= capture_d;
                            end
                        end else begin
                            slot_q <= slot_q + INDEX_WIDTH'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign pattern       = pattern_q;
    assign pattern_valid = valid_q;
    assign locked        = locked_q;
    assign slot_index    = slot_q;
    assign frame_done    = done_q;
    assign mismatch      = mismatch_q;

endmodule

// File: tb/tb_blink_pattern_decoder.sv
// Bench for blink_pattern_decoder: a blinker-like source drives LED_IN and a
// slot/frame-level model predicts every output cycle by cycle.
module tb_blink_pattern_decoder;

    localparam int MW = 32;
    localparam int IW = 5;
    localparam int SW = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          LED_IN = 1'b0;
    logic [MW-1:0] pattern;
    logic          pattern_valid;
    logic          locked;
    logic [IW-1:0] slot_index;
    logic          frame_done;
    logic          mismatch;

    blink_pattern_decoder #(
        .MESSAGE_WIDTH(MW),
        .INDEX_WIDTH  (IW),
        .SLOT_WIDTH   (SW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .LED_IN       (LED_IN),
        .pattern      (pattern),
        .pattern_valid(pattern_valid),
        .locked       (locked),
        .slot_index   (slot_index),
        .frame_done   (frame_done),
        .mismatch     (mismatch)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit        m_meta, m_s, m_sprev, m_edge;
    int        since, idle;
    bit        hunting;
    bit        q_bits[$];
    logic [31:0] m_word;
    logic [31:0] e_pat;
    bit        e_valid, e_locked, e_fd, e_mm;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_meta = 0; m_s = 0; m_sprev = 0;
            since = 0; idle = 0; hunting = 1;
            q_bits.delete();
            e_pat = '0; e_valid = 0; e_locked = 0; e_fd = 0; e_mm = 0;
        end else begin
            e_fd = 0;
            e_mm = 0;
            m_edge = m_s ^ m_sprev;
            if (m_edge) begin
                since = 0;
                if (hunting) begin
                    hunting = 0;
                    q_bits.delete();
                end
            end else begin
                if (hunting) begin
                    if (since % 8 == 7) begin
                        idle++;
                        if (idle == MW) begin
                            hunting = 0;
                            idle = 0;
                            q_bits.delete();
                        end
                    end
                end else if (since % 8 == 4) begin
                    q_bits.push_back(m_s);
                    if (q_bits.size() == MW) begin
                        for (int i = 0; i < MW; i++) m_word[i] = q_bits[i];
                        q_bits.delete();
                        e_fd = 1;
                        if (!e_valid) begin
                            e_pat = m_word;
                            e_valid = 1;
                        end else if (m_word == e_pat) begin
                            e_locked = 1;
                        end else begin
                            e_locked = 0;
                            e_mm = 1;
                            e_pat = m_word;
                        end
                    end
                end
                since++;
            end
            m_sprev = m_s;
            m_s = m_meta;
            m_meta = LED_IN;
        end
    end

    // ---------------- source (blinker with optional jitter / phase step) ----------------
    logic [7:0]  tx_cnt, off, p, prev_p;
    logic [31:0] tx_pat, chg_pat;
    bit          chg_pending, jit_en;
    int          j_cur, j_next, last_sh, lo, hi, w;
    int          fd_cnt = 0;
    int          mm_cnt = 0;

    function automatic logic bitv(input logic [4:0] k);
        return tx_pat[k];
    endfunction

    task automatic drive_led();
        logic [4:0] k;
        logic       lvl;
        p = tx_cnt - off;
        if (chg_pending && p == 8'd0) begin
            tx_pat = chg_pat;
            chg_pending = 0;
        end
        k = p[7:3];
        w = int'(p[2:0]);
        if (w == 0 && p != prev_p) begin
            j_cur = j_next;
            j_next = 0;
            if (bitv(k + 5'd1) != bitv(k)) begin
                // Keep successive transition shifts within the sampler's capture window.
                if (jit_en) begin
                    lo = (last_sh - 2 < -3) ? -3 : last_sh - 2;
                    hi = (last_sh + 4 > 3) ? 3 : last_sh + 4;
                    j_next = lo + int'($urandom_range(hi - lo));
                end else begin
                    j_next = (last_sh > 2) ? last_sh - 2 : 0;
                end
                last_sh = j_next;
            end
        end
        prev_p = p;
        lvl = bitv(k);
        if (j_cur > 0 && w < j_cur) lvl = bitv(k - 5'd1);
        if (j_next < 0 && w >= 8 + j_next) lvl = bitv(k + 5'd1);
        LED_IN = lvl;
    endtask

    task automatic step();
        int es;
        @(posedge CLK);
        #1;
        es = hunting ? (idle % MW) : q_bits.size();
        check("pattern", pattern, e_pat);
        check("pattern_valid", 32'(pattern_valid), 32'(e_valid));
        check("locked", 32'(locked), 32'(e_locked));
        check("slot_index", 32'(slot_index), es[31:0]);
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("mismatch", 32'(mismatch), 32'(e_mm));
        if (frame_done) fd_cnt++;
        if (mismatch) mm_cnt++;
        if (!RST) tx_cnt = tx_cnt + 8'd1;
        drive_led();
    endtask

    task automatic do_reset(input logic [31:0] pat);
        RST = 1'b1;
        tx_pat = pat; tx_cnt = '0; off = '0; prev_p = '0;
        jit_en = 0; chg_pending = 0;
        j_cur = 0; j_next = 0; last_sh = 0;
        drive_led();
        repeat (3) step();
        RST = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int start;
        int i;
        start = fd_cnt;
        i = 0;
        while (fd_cnt < start + n && i < budget) begin
            step();
            i++;
        end
        check(name, 32'(fd_cnt - start >= n), 32'd1);
    endtask

    int mm0;

    initial begin
        // Reset values with no clock edge yet.
        #1;
        check("rst_pattern", pattern, 32'h0);
        check("rst_valid", 32'(pattern_valid), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_slot", 32'(slot_index), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_mismatch", 32'(mismatch), 32'd0);

        // Loopback of 32'h5554FFFF.
        do_reset(32'h5554FFFF);
        mm0 = mm_cnt;
        wait_frames(1, 300, "loop_f1_timeout");
        check("loop_f1_valid", 32'(pattern_valid), 32'd1);
        check("loop_f1_pattern", pattern, 32'h5554FFFF);
        check("loop_f1_locked", 32'(locked), 32'd0);
        wait_frames(1, 300, "loop_f2_timeout");
        check("loop_f2_locked", 32'(locked), 32'd1);
        check("loop_f2_pattern", pattern, 32'h5554FFFF);

        // Edge jitter of up to 3 cycles.
        jit_en = 1;
        repeat (2) begin
            wait_frames(1, 300, "jit_timeout");
            check("jit_locked", 32'(locked), 32'd1);
            check("jit_pattern", pattern, 32'h5554FFFF);
        end
        jit_en = 0;
        wait_frames(1, 300, "jit_settle_timeout");
        check("jit_no_mismatch", 32'(mm_cnt - mm0), 32'd0);

        // Phase step of 5 cycles puts the next edge exactly on a strobe.
        begin
            int n;
            n = 0;
            while (p[2:0] != 3'd7 && n < 16) begin
                step();
                n++;
            end
        end
        off = 8'd5;
        drive_led();
        wait_frames(2, 600, "es_timeout");
        check("es_locked", 32'(locked), 32'd1);
        check("es_pattern", pattern, 32'h5554FFFF);
        check("es_no_mismatch", 32'(mm_cnt - mm0), 32'd0);

        // Pattern change at a frame boundary.
        chg_pat = 32'h0000FFFF;
        chg_pending = 1;
        begin
            int n;
            n = 0;
            while (chg_pending && n < 300) begin
                step();
                n++;
            end
        end
        repeat (16) step();
        wait_frames(1, 300, "chg_timeout");
        check("chg_mismatch_count", 32'(mm_cnt - mm0), 32'd1);
        check("chg_locked", 32'(locked), 32'd0);
        check("chg_pattern", pattern, 32'h0000FFFF);
        wait_frames(1, 300, "chg_relock_timeout");
        check("chg_relocked", 32'(locked), 32'd1);
        check("chg_mismatch_once", 32'(mm_cnt - mm0), 32'd1);

        // Asynchronous reset mid-frame.
        begin
            int n;
            n = 0;
            while (slot_index != 5'd17 && n < 300) begin
                step();
                n++;
            end
            check("mid_reached_17", 32'(slot_index), 32'd17);
        end
        #3;
        RST = 1'b1;
        #1;
        check("mid_pattern", pattern, 32'h0);
        check("mid_valid", 32'(pattern_valid), 32'd0);
        check("mid_locked", 32'(locked), 32'd0);
        check("mid_slot", 32'(slot_index), 32'd0);
        check("mid_frame_done", 32'(frame_done), 32'd0);
        check("mid_mismatch", 32'(mismatch), 32'd0);
        do_reset(32'h5554FFFF);
        mm0 = mm_cnt;
        wait_frames(2, 600, "mid_relock_timeout");
        check("mid_relock", 32'(locked), 32'd1);
        check("mid_relock_pattern", pattern, 32'h5554FFFF);

        // Constant low input: HUNT exits after 32 idle slots.
        do_reset(32'h0);
        mm0 = mm_cnt;
        repeat (100) step();
        check("const_idle_slot", 32'(slot_index), 32'd12);
        check("const_idle_valid", 32'(pattern_valid), 32'd0);
        wait_frames(2, 800, "const_timeout");
        check("const_pattern", pattern, 32'h0);
        check("const_valid", 32'(pattern_valid), 32'd1);
        check("const_locked", 32'(locked), 32'd1);
        check("const_no_mismatch", 32'(mm_cnt - mm0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/blink_pattern_decoder.md
# blink_pattern_decoder

Receive-side counterpart of `lookup_blinker`. Samples a slot-serial blink signal (one pattern bit per 2^SLOT_WIDTH clocks, bit 0 first, free-running) and recovers the MESSAGE_WIDTH-bit pattern. Phase is recovered from input transitions, and `locked` is declared once two consecutive frames match. It sits on a board input, or in loopback behind `lookup_blinker` for self-test.

## Interface
- MESSAGE_WIDTH, 32: pattern length in slots.
- INDEX_WIDTH, 5: log2(MESSAGE_WIDTH).
- SLOT_WIDTH, 21: slot length is 2^SLOT_WIDTH clocks. This equals the blinker's COUNTER_WIDTH-COUNTER_INDEX_WIDTH.

- CLK  in  1  single clock.
- RST  in  1  asynchronous, active-high reset.
- LED_IN  in  1  raw blink input, asynchronous to CLK.
- pattern  out  MESSAGE_WIDTH  last completed frame; bit i is slot i.
- pattern_valid  out  1  high after first frame completes.
- locked  out  1  high while the last two frames were identical.
- slot_index  out  INDEX_WIDTH  index of the next slot to be sampled.
- frame_done  out  1  one-cycle pulse per completed frame.
- mismatch  out  1  one-cycle pulse when a VERIFY frame differs from `pattern`.

## Operation
- **Synchronizer:** 2 flops, reset to 0. Call its output `s`; `edge = s ^ s_prev`, with `s_prev` reset to 0. A high input at reset release therefore counts as an edge.
- **Phase counter:** SLOT_WIDTH bits, reset 0.
  - On `edge`, load 0.
  - Otherwise increment, wrapping mod 2^SLOT_WIDTH.
- **Sample strobe:** asserted when phase == 2^(SLOT_WIDTH-1) and `edge` is 0. `edge` has priority, so no sample is taken in an edge cycle.
- **HUNT** (reset state):
  - No capture.
  - `slot_index` counts phase wraps as an idle counter.
  - First `edge` → CAPTURE with `slot_index` = 0.
  - Idle counter reaching MESSAGE_WIDTH wraps with no edge (constant input) → CAPTURE with `slot_index` = 0.
- **CAPTURE:**
  - Each strobe writes `capture[slot_index] <= s` and increments `slot_index`.
  - On the strobe with `slot_index` == MESSAGE_WIDTH-1: `pattern <= ` completed capture, `pattern_valid <= 1`, pulse `frame_done`, `slot_index` → 0, go to VERIFY.
- **VERIFY:** same sampling. At frame end, pulse `frame_done` and compare the completed capture to `pattern`.
  - Equal: `locked <= 1`.
  - Different: `locked <= 0`, pulse `mismatch`, `pattern <= ` new capture.
  - Stay in VERIFY.
- Edges re-phase only; they never change `slot_index`. A glitch re-phases the counter and is tolerated if the next true edge follows.
- Frame rotation: bit 0 is the slot beginning at the HUNT-exit edge. This matches `lookup_blinker` bit 0 when both leave reset together with the blinker's counter at 0.

## Timing
- **Reset values:** `pattern` 0, `pattern_valid` 0, `locked` 0, `slot_index` 0, `frame_done` 0, `mismatch` 0, state HUNT. RST clears all registers immediately, with no clock needed, including mid-frame.
- **Input latency:** LED_IN to `s` is 2 cycles.
- **Sample point:** 2^(SLOT_WIDTH-1) cycles after the edge-detect cycle.
- **Output update:** `pattern`, `pattern_valid`, `locked` and `mismatch` update in the cycle after the last strobe of a frame, coincident with `frame_done`.
- **Lock latency:** with a periodic input, `locked` rises at the end of the second full frame after HUNT exit.
- **Jitter tolerance:** an edge up to ±(2^(SLOT_WIDTH-1)-1) cycles from nominal must not cause a bit error.

## Test plan
All scenarios use SLOT_WIDTH=3 (8-clock slots), MESSAGE_WIDTH=32 and INDEX_WIDTH=5.
- **Loopback:** `lookup_blinker` (COUNTER_WIDTH=8, COUNTER_INDEX_WIDTH=5), pattern 32'h5554FFFF, RST released with blinker counter at 0 → `pattern` = 32'h5554FFFF, `pattern_valid` at frame 1 end, `locked` = 1 at frame 2 end, `mismatch` never pulses.
- **Constant LED_IN=0:** HUNT exits after 32 idle slots → `pattern` = 0, `locked` = 1 at the second frame end after exit, no edges.
- **Pattern change after lock** (32'h5554FFFF → 32'h0000FFFF at a frame boundary) → one `mismatch` pulse, `locked` = 0, `pattern` = 32'h0000FFFF. Next frame end: `locked` = 1.
- **Async RST mid-frame** (`slot_index` = 17) → all outputs 0 in the same timestep without a clock edge, then relock from HUNT.
- **Edge jitter:** transitions shifted ±3 cycles randomly → `pattern` correct, `locked` stays 1.
- **Edge in the same cycle as the strobe:** no sample, phase reloads 0, sample taken mid-slot later, `slot_index` not double-incremented.
